// File: rtl/fft_frame_loader.sv
// fft_frame_loader: assembles 8 complex FP16 samples into ping-pong frame banks for the FFT core
module fft_frame_loader #(
   parameter int DATA_W  = 16,
   parameter int N_PTS   = 8,
   parameter int EXP_MSB = 14,
   parameter int EXP_LSB = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_real,
   input  logic [DATA_W-1:0]       in_imag,
   input  logic                    in_mode,
   input  logic                    flush,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [N_PTS*DATA_W-1:0] frame_real,
   output logic [N_PTS*DATA_W-1:0] frame_imag,
   output logic                    frame_mode,
   output logic                    frame_bad,
   output logic [7:0]              frame_tag
);
   localparam int IW = $clog2(N_PTS);
   localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);

   logic [DATA_W-1:0] re_q [2][N_PTS];
   logic [DATA_W-1:0] im_q [2][N_PTS];
   logic [7:0]        tag_q [2];
   logic [1:0]        mode_q, bad_q, full_q, full_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, acc_q, acc_d;
   logic [IW-1:0]     wr_idx_q, wr_idx_d;
   logic [7:0]        tag_cnt_q, tag_cnt_d;
   logic              accept, last, rel, smp_bad;

   assign in_ready    = !full_q[wr_bank_q] && !flush;
   assign accept      = in_valid && in_ready;
   assign last        = wr_idx_q == LAST;
   assign frame_valid = full_q[rd_bank_q];
   assign rel         = frame_valid && frame_ready;
   assign smp_bad     = (&in_real[EXP_MSB:EXP_LSB]) || (&in_imag[EXP_MSB:EXP_LSB]);
   assign frame_mode  = mode_q[rd_bank_q];
   assign frame_bad   = bad_q[rd_bank_q];
   assign frame_tag   = tag_q[rd_bank_q];

   genvar k;
   generate
      for (k = 0; k < N_PTS; k++) begin : g_pack
         assign frame_real[k*DATA_W +: DATA_W] = re_q[rd_bank_q][k];
         assign frame_imag[k*DATA_W +: DATA_W] = im_q[rd_bank_q][k];
      end
   endgenerate

   // next state of write pointer, bad accumulator, tag counter and bank occupancy
   always_comb begin
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q ^ rel;
      acc_d     = acc_q;
      tag_cnt_d = tag_cnt_q;
      full_d    = full_q;
      if (rel) full_d[rd_bank_q] = 1'b0;
      if (flush) begin
         wr_idx_d = '0;
         acc_d    = 1'b0;
      end else if (accept) begin
         acc_d    = (wr_idx_q == '0) ? smp_bad : (acc_q | smp_bad);
         wr_idx_d = last ? '0 : wr_idx_q + 1'b1;
         if (last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            tag_cnt_d         = tag_cnt_q + 8'd1;
         end
      end
   end

   // control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         acc_q     <= 1'b0;
         tag_cnt_q <= '0;
         full_q    <= '0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         acc_q     <= acc_d;
         tag_cnt_q <= tag_cnt_d;
         full_q    <= full_d;
      end
   end

   // bank storage: sample write on accept, frame metadata captured at first and last sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N_PTS; i++) begin
               re_q[b][i] <= '0;
               im_q[b][i] <= '0;
            end
            tag_q[b] <= '0;
         end
         mode_q <= '0;
         bad_q  <= '0;
      end else if (accept) begin
         re_q[wr_bank_q][wr_idx_q] <= in_real;
         im_q[wr_bank_q][wr_idx_q] <= in_imag;
         if (wr_idx_q == '0) mode_q[wr_bank_q] <= in_mode;
         if (last) begin
            bad_q[wr_bank_q] <= acc_d;
            tag_q[wr_bank_q] <= tag_cnt_q;
         end
      end
   end
endmodule
